// File: rtl/xnor_stream_pkg.sv
// rtl/xnor_stream_pkg.sv - shared types and defaults for the XNOR stream checker
package xnor_stream_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DEF_LOCK_LEN    = 8;
    localparam int DEF_UNLOCK_MISS = 2;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/xnor_stream_checker_sat_counter.sv
// rtl/xnor_stream_checker_sat_counter.sv - saturating up-counter, clear applied before increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != '1)) begin
            cnt_d = base + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/xnor_stream_checker.sv
// rtl/xnor_stream_checker.sv - XNOR bit compare with run-length lock and locked-error counting
module xnor_stream_checker
    import xnor_stream_pkg::*;
#(
    parameter int LOCK_LEN    = DEF_LOCK_LEN,
    parameter int UNLOCK_MISS = DEF_UNLOCK_MISS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             err_clr,
    output logic             y,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] err_cnt,
    output logic             locked,
    output logic             lock_lost
);

    localparam int                MISS_W    = $clog2(UNLOCK_MISS + 1);
    localparam logic [CNT_W-1:0]  LOCK_M1   = CNT_W'(LOCK_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_MISS - 1);

    state_e            state_q, state_d;
    logic              y_q;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              lock_lost_q, lock_lost_d;

    logic eq, hit, mis, unlock;
    logic run_clr, run_inc, err_inc;

    assign eq     = ~(a ^ b);
    assign hit    = in_valid & eq;
    assign mis    = in_valid & ~eq;
    assign unlock = (state_q == LOCKED) && mis && (miss_q == MISS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            y_q         <= 1'b0;
            miss_q      <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            lock_lost_q <= lock_lost_d;
            if (in_valid) begin
                y_q <= eq;
            end
        end
    end

    // run_len still shows the pre-edge count, so the LOCK_LEN-th match is seen as LOCK_LEN-1 here
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (hit && (run_len == LOCK_M1)) state_d = LOCKED;
            LOCKED:  if (unlock) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        run_inc     = hit;
        run_clr     = ((state_q == SEARCH) && mis) || unlock;
        err_inc     = (state_q == LOCKED) && mis;
        lock_lost_d = unlock;
        miss_d      = miss_q;
        if (state_q == LOCKED) begin
            if (hit || unlock) begin
                miss_d = '0;
            end else if (mis) begin
                miss_d = miss_q + MISS_W'(1);
            end
        end else begin
            miss_d = '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (run_clr),
        .inc_i (run_inc),
        .cnt_o (run_len)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (err_clr),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    assign y         = y_q;
    assign locked    = (state_q == LOCKED);
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_xnor_stream_checker.sv
// tb/tb_xnor_stream_checker.sv - directed self-checking bench for xnor_stream_checker
module tb_xnor_stream_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       err_clr = 1'b0;

    logic       y, locked, lock_lost;
    logic [7:0] run_len, err_cnt;
    logic       y2, locked2, lock_lost2;
    logic [3:0] run_len2, err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xnor_stream_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .err_clr(err_clr),
        .y(y), .run_len(run_len), .err_cnt(err_cnt), .locked(locked), .lock_lost(lock_lost)
    );

    xnor_stream_checker #(.LOCK_LEN(2), .UNLOCK_MISS(20), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .err_clr(err_clr),
        .y(y2), .run_len(run_len2), .err_cnt(err_cnt2), .locked(locked2), .lock_lost(lock_lost2)
    );

    task automatic step(input logic v, input logic ia, input logic ib, input logic iclr);
        in_valid = v;
        a        = ia;
        b        = ib;
        err_clr  = iclr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({y, run_len, err_cnt, locked, lock_lost} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h expected=0", {y, run_len, err_cnt, locked, lock_lost});
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            checks++;
            if (run_len !== 8'(i)) begin
                errors++;
                $display("FAIL lock_run_len step=%0d actual=%0d expected=%0d", i, run_len, i);
            end
            checks++;
            if (locked !== (i == 8)) begin
                errors++;
                $display("FAIL lock_locked step=%0d actual=%b expected=%b", i, locked, (i == 8));
            end
        end
        checks++;
        if (err_cnt !== 8'd0 || y !== 1'b1) begin
            errors++;
            $display("FAIL lock_err_y actual=%0d/%b expected=0/1", err_cnt, y);
        end
    endtask

    task automatic test_single_miss();
        test_lock();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({y, err_cnt, locked, run_len} !== {1'b0, 8'd1, 1'b1, 8'd8}) begin
            errors++;
            $display("FAIL single_miss y=%b err=%0d locked=%b run=%0d expected 0/1/1/8", y, err_cnt, locked, run_len);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({y, locked, run_len} !== {1'b1, 1'b1, 8'd9}) begin
            errors++;
            $display("FAIL single_recover y=%b locked=%b run=%0d expected 1/1/9", y, locked, run_len);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({err_cnt, locked, lock_lost} !== {8'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL miss_reset err=%0d locked=%b lost=%b expected 2/1/0", err_cnt, locked, lock_lost);
        end
    endtask

    task automatic test_unlock();
        test_lock();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({err_cnt, lock_lost, locked, run_len} !== {8'd2, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL unlock err=%0d lost=%b locked=%b run=%0d expected 2/1/0/0", err_cnt, lock_lost, locked, run_len);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_pulse actual=%b expected=0", lock_lost);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({err_cnt, run_len, locked} !== {8'd2, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL search_no_err err=%0d run=%0d locked=%b expected 2/0/0", err_cnt, run_len, locked);
        end
    endtask

    task automatic test_search();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (run_len !== 8'd5) begin
            errors++;
            $display("FAIL search_run5 actual=%0d expected=5", run_len);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({run_len, err_cnt, locked} !== {8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL search_break run=%0d err=%0d locked=%b expected 0/0/0", run_len, err_cnt, locked);
        end
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL search_early_lock actual=%b expected=0", locked);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({locked, run_len, err_cnt} !== {1'b1, 8'd8, 8'd0}) begin
            errors++;
            $display("FAIL search_relock locked=%b run=%0d err=%0d expected 1/8/0", locked, run_len, err_cnt);
        end
    endtask

    task automatic test_gap();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({run_len, y} !== {8'd3, 1'b1}) begin
            errors++;
            $display("FAIL gap_hold run=%0d y=%b expected 3/1", run_len, y);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (run_len !== 8'd4) begin
            errors++;
            $display("FAIL gap_resume actual=%0d expected=4", run_len);
        end
    endtask

    task automatic test_rst_locked();
        test_lock();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({err_cnt, locked} !== {8'd3, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst err=%0d locked=%b expected 3/1", err_cnt, locked);
        end
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if ({y, run_len, err_cnt, locked, lock_lost} !== 19'd0) begin
            errors++;
            $display("FAIL rst_locked actual=%h expected=0", {y, run_len, err_cnt, locked, lock_lost});
        end
    endtask

    task automatic test_err_clr_sat();
        int exp;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (locked2 !== 1'b1) begin
            errors++;
            $display("FAIL small_lock actual=%b expected=1", locked2);
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, 1'b1, (k == 3));
            exp = (k < 3) ? k : ((k - 2 > 15) ? 15 : k - 2);
            checks++;
            if (err_cnt2 !== 4'(exp)) begin
                errors++;
                $display("FAIL clr_sat k=%0d actual=%0d expected=%0d", k, err_cnt2, exp);
            end
            checks++;
            if ({locked2, lock_lost2} !== {(k < 20), (k == 20)}) begin
                errors++;
                $display("FAIL small_unlock k=%0d actual=%b%b expected=%b%b", k, locked2, lock_lost2, (k < 20), (k == 20));
            end
        end
    endtask

    task automatic test_run_sat();
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (run_len2 !== 4'd15) begin
            errors++;
            $display("FAIL run_sat actual=%0d expected=15", run_len2);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_miss();
        test_unlock();
        test_search();
        test_gap();
        test_rst_locked();
        test_err_clr_sat();
        test_run_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
